// File: rtl/mem_access_stage_if.sv
// EXE->MEM->WB handshake, data-RAM port and bypass signals of the memory-access stage.
// slave: the stage itself; master: whatever drives EXE inputs, the RAM and WB.
interface mem_access_stage_if #(
    parameter int unsigned SIDE_W = 64
);
    logic              in_valid;
    logic              in_ready;
    logic [4:0]        mem_op;
    logic [31:0]       addr;
    logic [31:0]       store_data;
    logic              rf_wen;
    logic [4:0]        wdest;
    logic [31:0]       pc;
    logic [SIDE_W-1:0] side_in;
    logic              flush;

    logic              dm_en;
    logic [3:0]        dm_wen;
    logic [31:0]       dm_addr;
    logic [31:0]       dm_wdata;
    logic [31:0]       dm_rdata;

    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_result;
    logic              out_rf_wen;
    logic [4:0]        out_wdest;
    logic [31:0]       out_pc;
    logic [SIDE_W-1:0] out_side;
    logic              out_adel;
    logic              out_ades;

    logic [4:0]        fwd_wdest;
    logic [31:0]       fwd_value;
    logic              fwd_ready;

    modport master (
        output in_valid, mem_op, addr, store_data, rf_wen, wdest, pc, side_in, flush,
        output dm_rdata, out_ready,
        input  in_ready, dm_en, dm_wen, dm_addr, dm_wdata,
        input  out_valid, out_result, out_rf_wen, out_wdest, out_pc, out_side, out_adel, out_ades,
        input  fwd_wdest, fwd_value, fwd_ready
    );

    modport slave (
        input  in_valid, mem_op, addr, store_data, rf_wen, wdest, pc, side_in, flush,
        input  dm_rdata, out_ready,
        output in_ready, dm_en, dm_wen, dm_addr, dm_wdata,
        output out_valid, out_result, out_rf_wen, out_wdest, out_pc, out_side, out_adel, out_ades,
        output fwd_wdest, fwd_value, fwd_ready
    );
endinterface

// File: rtl/mem_access_stage.sv
// MIPS MEM stage: byte/half/word loads and stores against a fixed-latency data RAM.
// Define MEM_ALIGN_CHECK_EN to raise out_adel/out_ades on misaligned accesses.
module mem_access_stage #(
    parameter int unsigned RD_LATENCY = 1,
    parameter int unsigned SIDE_W     = 64
) (
    input logic               clk,
    input logic               resetn,
    mem_access_stage_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t            state, next_state, entry_state;
    logic [2:0]        cnt;
    logic [4:0]        r_op;
    logic [31:0]       r_addr, r_sdata, r_res, r_pc;
    logic              r_rf_wen, r_mis;
    logic [4:0]        r_wdest;
    logic [SIDE_W-1:0] r_side;

    logic in_is_mem, in_mis, accept;
    logic r_is_load, r_is_store, load_result;

    function automatic logic [31:0] load_extract(input logic [2:0] op, input logic [1:0] lo,
                                                 input logic [31:0] rdata);
        logic [7:0]  b;
        logic [15:0] h;
        b = 8'(rdata >> {lo, 3'b000});
        h = lo[1] ? rdata[31:16] : rdata[15:0];
        case (op[2:1])
            2'b00:   return op[0] ? {24'b0, b} : {{24{b[7]}}, b};
            2'b01:   return op[0] ? {16'b0, h} : {{16{h[15]}}, h};
            default: return rdata;
        endcase
    endfunction

    function automatic logic [3:0] store_strobe(input logic [1:0] size, input logic [1:0] lo);
        case (size)
            2'b00:   return 4'b0001 << lo;
            2'b01:   return lo[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] store_lanes(input logic [1:0] size, input logic [31:0] d);
        case (size)
            2'b00:   return {4{d[7:0]}};
            2'b01:   return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

    assign in_is_mem = bus.mem_op[4] | bus.mem_op[3];
`ifdef MEM_ALIGN_CHECK_EN
    assign in_mis = in_is_mem &
                    (((bus.mem_op[2:1] == 2'b01) & bus.addr[0]) |
                     (bus.mem_op[2] & (bus.addr[1:0] != 2'b00)));
`else
    assign in_mis = 1'b0;
`endif

    assign bus.in_ready = (state == IDLE) | ((state == DONE) & bus.out_ready);
    assign accept       = bus.in_valid & bus.in_ready & ~bus.flush;
    assign entry_state  = (in_is_mem & ~in_mis) ? ISSUE : DONE;

    assign r_is_load   = r_op[4];
    assign r_is_store  = r_op[3] & ~r_op[4];
    assign load_result = r_is_load & ~r_mis;

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept) next_state = entry_state;
            ISSUE:   next_state = r_is_load ? WAIT : DONE;
            WAIT:    if (cnt == '0) next_state = DONE;
            DONE:    if (bus.out_ready) next_state = accept ? entry_state : IDLE;
            default: next_state = IDLE;
        endcase
        if (bus.flush) next_state = IDLE;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= IDLE;
            cnt      <= '0;
            r_op     <= '0;
            r_addr   <= '0;
            r_sdata  <= '0;
            r_res    <= '0;
            r_pc     <= '0;
            r_rf_wen <= 1'b0;
            r_mis    <= 1'b0;
            r_wdest  <= '0;
            r_side   <= '0;
        end else begin
            state <= next_state;
            if (accept) begin
                r_op     <= bus.mem_op;
                r_addr   <= bus.addr;
                r_sdata  <= bus.store_data;
                r_rf_wen <= bus.rf_wen & ~in_mis;
                r_mis    <= in_mis;
                r_wdest  <= bus.wdest;
                r_pc     <= bus.pc;
                r_side   <= bus.side_in;
            end
            if (state == ISSUE)
                cnt <= 3'(RD_LATENCY - 1);
            else if (state == WAIT && cnt != '0)
                cnt <= cnt - 3'd1;
            // a flush in the final WAIT cycle discards the returning read data
            if (state == WAIT && cnt == '0 && !bus.flush)
                r_res <= load_extract(r_op[2:0], r_addr[1:0], bus.dm_rdata);
        end
    end

    assign bus.dm_en    = (state == ISSUE) & ~bus.flush;
    assign bus.dm_wen   = (state == ISSUE && r_is_store && !bus.flush)
                          ? store_strobe(r_op[2:1], r_addr[1:0]) : '0;
    assign bus.dm_addr  = {r_addr[31:2], 2'b00};
    assign bus.dm_wdata = store_lanes(r_op[2:1], r_sdata);

    assign bus.out_valid  = (state == DONE) & ~bus.flush;
    assign bus.out_result = load_result ? r_res : r_addr;
    assign bus.out_rf_wen = r_rf_wen;
    assign bus.out_wdest  = r_wdest;
    assign bus.out_pc     = r_pc;
    assign bus.out_side   = r_side;
    assign bus.out_adel   = r_mis & r_is_load;
    assign bus.out_ades   = r_mis & r_is_store;

    assign bus.fwd_wdest = (state != IDLE && r_rf_wen) ? r_wdest : '0;
    assign bus.fwd_ready = ~(r_is_load & ((state == ISSUE) | (state == WAIT)));
    assign bus.fwd_value = (load_result && state == DONE) ? r_res : r_addr;
endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: directed cases plus random ops against a byte-level RAM model.
module tb_mem_access_stage;
    localparam int unsigned RD_LAT = 3;
    localparam int unsigned SW     = 64;
`ifdef MEM_ALIGN_CHECK_EN
    localparam bit ALIGN_CHK = 1'b1;
`else
    localparam bit ALIGN_CHK = 1'b0;
`endif

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    mem_access_stage_if #(.SIDE_W(SW)) bus();
    mem_access_stage #(.RD_LATENCY(RD_LAT), .SIDE_W(SW)) dut (
        .clk(clk), .resetn(resetn), .bus(bus)
    );

    int checks = 0;
    int errors = 0;

    logic [31:0] phys  [0:255];
    logic [31:0] model [0:255];
    logic [7:0]  rd_idx = '0;
    logic        filled = 1'b0;

    function automatic logic [31:0] pat(input int i);
        return 32'(i) * 32'h9E3779B9 ^ 32'h5A5A1234;
    endfunction

    // RAM environment: latches the read address on a read strobe, writes byte lanes on write strobes
    assign bus.dm_rdata = phys[rd_idx];
    always @(posedge clk) begin : ram
        logic [31:0] w;
        if (!filled) begin
            for (int i = 0; i < 256; i++) phys[i] <= pat(i);
            filled <= 1'b1;
        end else if (bus.dm_en) begin
            if (bus.dm_wen == 4'b0000) rd_idx <= bus.dm_addr[9:2];
            else begin
                w = phys[bus.dm_addr[9:2]];
                for (int k = 0; k < 4; k++)
                    if (bus.dm_wen[k]) w[8*k +: 8] = bus.dm_wdata[8*k +: 8];
                phys[bus.dm_addr[9:2]] <= w;
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic int size_bytes(input logic [4:0] op);
        case (op[2:1])
            2'b00:   return 1;
            2'b01:   return 2;
            default: return 4;
        endcase
    endfunction

    function automatic logic is_mis(input logic [4:0] op, input logic [31:0] a);
        int n;
        if (op[4:3] == 2'b00) return 1'b0;
        n = size_bytes(op);
        return ALIGN_CHK && (int'(a[1:0]) % n != 0);
    endfunction

    function automatic logic [31:0] model_load(input logic [4:0] op, input logic [31:0] a);
        int n, off;
        logic [31:0] w, r;
        n   = size_bytes(op);
        off = (int'(a[1:0]) / n) * n;
        w   = model[a[9:2]];
        r   = '0;
        for (int i = 0; i < n; i++) r[8*i +: 8] = w[8*(off+i) +: 8];
        if (!op[0] && n < 4 && r[8*n-1])
            for (int i = n; i < 4; i++) r[8*i +: 8] = 8'hFF;
        return r;
    endfunction

    // One instruction through an idle stage with WB always ready; checks everything against the model.
    task automatic run_op(input string tag, input logic [4:0] op, input logic [31:0] a,
                          input logic [31:0] sd, output logic [31:0] res_o,
                          output logic [3:0] wen_o, output logic [31:0] wdata_o);
        logic [4:0]  wd;
        logic        rw, mis, ld, st, fr_bad;
        logic [31:0] pcv, exp_res, seen_addr, exp_wdata;
        logic [63:0] sv;
        logic [3:0]  seen_wen, exp_wen;
        int n, off, exp_lat, cyc, en_cnt;

        wd  = 5'($urandom_range(1, 31));
        rw  = 1'($urandom);
        pcv = $urandom;
        sv  = {$urandom, $urandom};
        mis = is_mis(op, a);
        ld  = op[4];
        st  = op[3] & ~op[4];
        n   = size_bytes(op);
        off = (int'(a[1:0]) / n) * n;
        exp_wen = '0;
        exp_wdata = '0;
        for (int i = 0; i < n; i++) exp_wen[off+i] = 1'b1;
        for (int j = 0; j < 4; j++) exp_wdata[8*j +: 8] = sd[8*(j % n) +: 8];
        exp_res = (ld && !mis) ? model_load(op, a) : a;
        exp_lat = (mis || !(ld || st)) ? 1 : (st ? 2 : int'(RD_LAT) + 2);

        bus.mem_op = op; bus.addr = a; bus.store_data = sd; bus.rf_wen = rw;
        bus.wdest = wd; bus.pc = pcv; bus.side_in = sv; bus.out_ready = 1'b1;
        bus.in_valid = 1'b1;
        tick;
        bus.in_valid = 1'b0;
        cyc = 1; en_cnt = 0; seen_wen = '0; seen_addr = '0; fr_bad = 1'b0;
        wdata_o = '0;
        check({tag, "/fwd_ready_c1"}, 64'(bus.fwd_ready), 64'(!(ld && !mis)));
        while (!bus.out_valid && cyc < 40) begin
            if (bus.dm_en) begin
                en_cnt++;
                seen_wen = bus.dm_wen; seen_addr = bus.dm_addr; wdata_o = bus.dm_wdata;
            end
            if (ld && bus.fwd_ready) fr_bad = 1'b1;
            tick;
            cyc++;
        end
        check({tag, "/latency"}, 64'(cyc), 64'(exp_lat));
        check({tag, "/dm_en_cnt"}, 64'(en_cnt), 64'((ld || st) && !mis));
        if ((ld || st) && !mis) begin
            check({tag, "/dm_addr"}, 64'(seen_addr), 64'({a[31:2], 2'b00}));
            check({tag, "/dm_wen"}, 64'(seen_wen), 64'(st ? exp_wen : 4'b0000));
            if (st) check({tag, "/dm_wdata"}, 64'(wdata_o), 64'(exp_wdata));
            if (ld) check({tag, "/fwd_ready_wait"}, 64'(fr_bad), 64'(0));
        end
        check({tag, "/result"}, 64'(bus.out_result), 64'(exp_res));
        check({tag, "/rf_wen"}, 64'(bus.out_rf_wen), 64'(rw && !mis));
        check({tag, "/wdest"}, 64'(bus.out_wdest), 64'(wd));
        check({tag, "/pc"}, 64'(bus.out_pc), 64'(pcv));
        check({tag, "/side"}, bus.out_side, sv);
        check({tag, "/adel"}, 64'(bus.out_adel), 64'(mis && ld));
        check({tag, "/ades"}, 64'(bus.out_ades), 64'(mis && st));
        check({tag, "/fwd_wdest"}, 64'(bus.fwd_wdest), 64'((rw && !mis) ? wd : 5'd0));
        check({tag, "/fwd_value"}, 64'(bus.fwd_value), 64'(exp_res));
        check({tag, "/fwd_ready"}, 64'(bus.fwd_ready), 64'(1));
        res_o = bus.out_result;
        wen_o = seen_wen;
        if (st && !mis)
            for (int i = 0; i < n; i++) model[a[9:2]][8*(off+i) +: 8] = sd[8*i +: 8];
        tick;
        check({tag, "/idle_after"}, 64'(bus.out_valid), 64'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] res, wd_out, held;
        logic [3:0]  wen;
        logic [4:0]  op;
        logic [31:0] items [4];
        bit          rdy_pat [4];
        int kind, acc, del, pidx, guard, nstall;
        logic stalled;

        for (int i = 0; i < 256; i++) model[i] = pat(i);
        bus.in_valid = 1'b0; bus.mem_op = '0; bus.addr = '0; bus.store_data = '0;
        bus.rf_wen = 1'b0; bus.wdest = '0; bus.pc = '0; bus.side_in = '0;
        bus.flush = 1'b0; bus.out_ready = 1'b0;

        // reset state
        resetn = 1'b0;
        #12;
        check("rst/in_ready", 64'(bus.in_ready), 64'(1));
        check("rst/out_valid", 64'(bus.out_valid), 64'(0));
        check("rst/dm_en", 64'(bus.dm_en), 64'(0));
        check("rst/dm_wen", 64'(bus.dm_wen), 64'(0));
        check("rst/out_result", 64'(bus.out_result), 64'(0));
        check("rst/fwd_wdest", 64'(bus.fwd_wdest), 64'(0));
        check("rst/out_rf_wen", 64'(bus.out_rf_wen), 64'(0));
        @(negedge clk);
        resetn = 1'b1;
        tick;

        // directed memory accesses
        run_op("sw100", 5'b01100, 32'h100, 32'hDEADBEEF, res, wen, wd_out);
        check("sw100/wen_const", 64'(wen), 64'(4'b1111));
        run_op("sb203", 5'b01000, 32'h203, 32'h000000A5, res, wen, wd_out);
        check("sb203/wen_const", 64'(wen), 64'(4'b1000));
        check("sb203/wdata_const", 64'(wd_out), 64'(32'hA5A5A5A5));
        run_op("sh202", 5'b01010, 32'h202, 32'h00001234, res, wen, wd_out);
        check("sh202/wen_const", 64'(wen), 64'(4'b1100));
        run_op("sw300", 5'b01100, 32'h300, 32'h00008000, res, wen, wd_out);
        run_op("lb301", 5'b10000, 32'h301, 32'h0, res, wen, wd_out);
        check("lb301/const", 64'(res), 64'(32'hFFFFFF80));
        run_op("lbu301", 5'b10001, 32'h301, 32'h0, res, wen, wd_out);
        check("lbu301/const", 64'(res), 64'(32'h00000080));
        run_op("lw102", 5'b10100, 32'h102, 32'h0, res, wen, wd_out);
`ifdef MEM_ALIGN_CHECK_EN
        check("lw102/const", 64'(res), 64'(32'h102));
`else
        check("lw102/const", 64'(res), 64'(32'hDEADBEEF));
`endif

        // random mix of ALU ops, loads and stores
        for (int t = 0; t < 40; t++) begin
            kind = int'($urandom_range(0, 2));
            case (kind)
                0:       op = {2'b00, 3'($urandom)};
                1:       op = {2'b10, 2'($urandom_range(0, 2)), 1'($urandom)};
                default: op = {2'b01, 2'($urandom_range(0, 2)), 1'b0};
            endcase
            run_op($sformatf("rnd%0d", t), op, {22'b0, 10'($urandom)}, $urandom, res, wen, wd_out);
        end

        // ALU stream with WB backpressure 1,0,1,1
        for (int i = 0; i < 4; i++) items[i] = $urandom;
        rdy_pat = '{1'b1, 1'b0, 1'b1, 1'b1};
        acc = 0; del = 0; pidx = 0; guard = 0; nstall = 0; stalled = 1'b0; held = '0;
        bus.mem_op = 5'b00000; bus.rf_wen = 1'b1; bus.wdest = 5'd7;
        while (del < 4 && guard < 30) begin
            bus.in_valid  = (acc < 4);
            bus.addr      = items[(acc < 4) ? acc : 3];
            bus.out_ready = (pidx < 4) ? rdy_pat[pidx] : 1'b1;
            #1;
            if (stalled) begin
                check("stream/hold_valid", 64'(bus.out_valid), 64'(1));
                check("stream/stable", 64'(bus.out_result), 64'(held));
            end
            if (bus.out_valid) begin
                if (bus.out_ready) begin
                    check($sformatf("stream/order%0d", del), 64'(bus.out_result), 64'(items[del]));
                    del++;
                    stalled = 1'b0;
                end else begin
                    stalled = 1'b1;
                    held = bus.out_result;
                    nstall++;
                end
                pidx++;
            end
            if (bus.in_valid && bus.in_ready) acc++;
            tick;
            guard++;
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        check("stream/count", 64'(del), 64'(4));
        check("stream/stalls", 64'(nstall), 64'(1));
        check("stream/cycles", 64'(guard), 64'(6));
        #1;
        check("stream/idle", 64'(bus.out_valid), 64'(0));

        // flush during ISSUE of a store: no write strobe, idle next cycle
        bus.mem_op = 5'b01100; bus.addr = 32'h3F0; bus.store_data = 32'h12345678;
        bus.in_valid = 1'b1;
        tick;
        bus.in_valid = 1'b0;
        check("flush/pre_en", 64'(bus.dm_en), 64'(1));
        bus.flush = 1'b1;
        #1;
        check("flush/dm_en", 64'(bus.dm_en), 64'(0));
        check("flush/dm_wen", 64'(bus.dm_wen), 64'(0));
        check("flush/out_valid", 64'(bus.out_valid), 64'(0));
        tick;
        bus.flush = 1'b0;
        #1;
        check("flush/idle_ready", 64'(bus.in_ready), 64'(1));
        check("flush/idle_valid", 64'(bus.out_valid), 64'(0));
        check("flush/fwd_wdest", 64'(bus.fwd_wdest), 64'(0));
        run_op("flush_lw3f0", 5'b10100, 32'h3F0, 32'h0, res, wen, wd_out);

        // reset asserted while a load waits for RAM data
        bus.mem_op = 5'b10100; bus.addr = 32'h104; bus.rf_wen = 1'b1; bus.wdest = 5'd9;
        bus.in_valid = 1'b1;
        tick;
        bus.in_valid = 1'b0;
        tick;
        check("rstwait/fwd_ready_pre", 64'(bus.fwd_ready), 64'(0));
        check("rstwait/fwd_wdest_pre", 64'(bus.fwd_wdest), 64'(9));
        resetn = 1'b0;
        #1;
        check("rstwait/dm_en", 64'(bus.dm_en), 64'(0));
        check("rstwait/out_valid", 64'(bus.out_valid), 64'(0));
        check("rstwait/fwd_ready", 64'(bus.fwd_ready), 64'(1));
        check("rstwait/fwd_wdest", 64'(bus.fwd_wdest), 64'(0));
        check("rstwait/in_ready", 64'(bus.in_ready), 64'(1));
        @(negedge clk);
        resetn = 1'b1;
        tick;
        run_op("post_rst_lh", 5'b10010, 32'h106, 32'h0, res, wen, wd_out);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

Parametrised memory-access pipeline stage for the five-stage MIPS core, sitting between EXE and WB. Holds one instruction, performs byte/half/word loads and stores with sign/zero extension against a data RAM of configurable fixed read latency, detects misaligned accesses, and exposes forwarding information to the bypass network. Uses a valid/ready handshake on both sides and a one-entry output register.

## Interface
- RD_LATENCY, 1: data-RAM read latency in cycles (legal 1..8)
- SIDE_W, 64: width of opaque side-band bus passed through to WB (HI/LO, CP0 fields)
- clk  in  1  clock
- resetn  in  1  reset; one clock, asynchronous active-low reset
- in_valid  in  1  EXE holds a valid instruction
- in_ready  out  1  stage accepts this cycle (MEM_allow_in)
- mem_op  in  5  [4] load, [3] store, [2:1] size 00 byte/01 half/10 word, [0] unsigned load
- addr  in  32  EXE result; memory address for load/store, result otherwise
- store_data  in  32  rt value for stores
- rf_wen / wdest / pc  in  1/5/32  writeback control and PC
- side_in  in  SIDE_W  pass-through fields
- flush  in  1  kill held instruction
- dm_en  out  1  RAM access strobe
- dm_wen  out  4  byte write enables
- dm_addr / dm_wdata  out  32/32  RAM address (word-aligned, addr[1:0] zeroed) and data
- dm_rdata  in  32  RAM read data
- out_valid  out  1  result valid to WB
- out_ready  in  1  WB accepts
- out_result / out_rf_wen / out_wdest / out_pc / out_side  out  32/1/5/32/SIDE_W
- out_adel / out_ades  out  1/1  load/store address error (result = bad address)
- fwd_wdest  out  5  destination of held instruction, 0 if none
- fwd_value  out  32  value for bypass
- fwd_ready  out  1  fwd_value is final (not a pending load)

## Operation
- States: IDLE, ISSUE, WAIT, DONE. Fields registered on acceptance.
- in_ready = (IDLE) or (DONE and out_ready). Accept = in_valid & in_ready & !flush.
- On accept: legal load/store -> ISSUE; non-memory op or misaligned access -> DONE.
- ISSUE (exactly one cycle): dm_en=1. Store: dm_wen per size, -> DONE. Load: dm_wen=0, cnt<=RD_LATENCY-1, -> WAIT.
- WAIT: cnt==0 -> capture extracted dm_rdata into result register, -> DONE; else cnt--.
- DONE: out_valid=1; on out_ready leave to IDLE, or directly to next state if accepting.
- Store data: byte replicated to all four lanes, dm_wen one-hot by addr[1:0]; half {h,h}, dm_wen 0011 (addr[1]=0) / 1100; word 1111.
- Load: byte lane by addr[1:0], half by addr[1], word whole; sign-extend unless mem_op[0].
- Misalignment: half with addr[0]=1, word with addr[1:0]!=0. No dm_en; out_adel (load) or out_ades (store) set; out_result=addr; out_rf_wen forced 0.
- flush: combinationally forces dm_en=0, dm_wen=0, out_valid=0; state -> IDLE at next edge; in-flight read data discarded; no accept that cycle.
- Forwarding: fwd_wdest = wdest when state!=IDLE and effective rf_wen, else 0. fwd_ready=0 for load in ISSUE/WAIT, else 1. fwd_value = result register for loads in DONE, else registered addr.

## Timing
- Reset: state IDLE; all outputs 0 (in_ready=1 is combinational from IDLE).
- Reset asserted mid-operation: immediate return to IDLE, dm_en/dm_wen drop asynchronously, held entry lost.
- Latency from accept edge to out_valid: non-memory/misaligned 1 cycle; store 2; load RD_LATENCY+2.
- Throughput: non-memory ops back-to-back one per cycle with out_ready=1.
- out_* stable while out_valid & !out_ready.
- Store write strobe asserted once regardless of WB backpressure.

## Configuration
- MEM_ALIGN_CHECK_EN defined: misalignment detection as above.
- Undefined: out_adel/out_ades tied 0; half ignores addr[0], word ignores addr[1:0] (access forced aligned), all loads/stores issue.

## Test plan
- sw addr 0x100 data 0xDEADBEEF -> one ISSUE cycle, dm_wen=1111, dm_addr=0x100; out_valid 2 cycles after accept.
- sb addr 0x203 data 0x000000A5 -> dm_wen=1000, dm_wdata=0xA5A5A5A5; sh addr 0x202 -> dm_wen=1100.
- RD_LATENCY=3, lb addr 0x301, rdata 0x0000_8000... i.e. 0x00008000 -> out_result 0xFFFFFF80, lbu -> 0x00000080; out_valid 5 cycles after accept; fwd_ready low until DONE.
- lw addr 0x102 (MEM_ALIGN_CHECK_EN) -> no dm_en, out_adel=1, out_result=0x102, out_rf_wen=0; without macro -> reads 0x100.
- Stream of 4 ALU ops with out_ready toggling 1,0,1,1 -> no loss/duplication, out_* stable during stall.
- flush during ISSUE of sw -> dm_wen=0000 that cycle, IDLE next; resetn low during WAIT -> dm_en=0, out_valid=0 immediately.
